// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Controller state: normal flow, or waiting on data memory.
    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } hazard_state_t;

    // Default register-index and performance-counter widths.
    localparam int HZ_REG_AW = 5;
    localparam int HZ_CNT_W  = 32;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    localparam int X0_IDX = 0;

    // Width of the memory-wait counter; MAX_WAIT is limited to 1..255.
    localparam int WAIT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled edges and holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Count on inc, stopping at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use bubbles,
// taken-branch squash, and whole-pipeline freeze on pending data memory,
// with saturating performance counters and a memory-wait watchdog.
//
// Handshake: data memory is busy in any cycle with mem_req_MEM=1 and
// mem_ack_MEM=0 (freeze). A cycle with mem_ack_MEM=1 completes the request
// and is handled by the normal (non-frozen) rules in that same cycle.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = HZ_REG_AW,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = HZ_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic              use_rs1_ID,
    input  logic              use_rs2_ID,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic              memread_EX,
    input  logic              branch_taken_EX,
    input  logic              mem_req_MEM,
    input  logic              mem_ack_MEM,
    output logic              stall_IF,
    output logic              stall_IFID,
    output logic              flush_IFID,
    output logic              flush_IDEX,
    output logic              stall_IDEX,
    output logic              stall_EXMEM,
    output logic              timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output hazard_state_t     dbg_state
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);
    localparam logic [REG_AW-1:0] X0         = REG_AW'(X0_IDX);

    hazard_state_t     r_state;
    hazard_state_t     w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_next;
    logic              r_timeout;
    logic              w_timeout_next;
    logic              w_freeze;
    logic              w_lu;
    logic              w_branch_fire;

    // Hazard conditions decoded from the current stage contents.
    assign w_freeze = mem_req_MEM & ~mem_ack_MEM;
    assign w_lu     = memread_EX & (rd_EX != X0) &
                      ((use_rs1_ID & (rs1_ID == rd_EX)) |
                       (use_rs2_ID & (rs2_ID == rd_EX)));

    // Next-state and prioritised stall/flush decode: freeze > branch > load-use.
    always_comb begin
        w_state_next   = r_state;
        w_wait_next    = r_wait_cnt;
        w_timeout_next = r_timeout;
        w_branch_fire  = 1'b0;
        stall_IF       = 1'b0;
        stall_IFID     = 1'b0;
        flush_IFID     = 1'b0;
        flush_IDEX     = 1'b0;
        stall_IDEX     = 1'b0;
        stall_EXMEM    = 1'b0;
        if (reset) begin
            w_state_next = RUN;
            w_wait_next  = '0;
        end else if (w_freeze) begin
            // Hold every stage; branch or load-use re-evaluates after the freeze.
            stall_IF    = 1'b1;
            stall_IFID  = 1'b1;
            stall_IDEX  = 1'b1;
            stall_EXMEM = 1'b1;
            if (r_state == RUN) begin
                w_state_next = MEMWAIT;
                w_wait_next  = {{(WAIT_W-1){1'b0}}, 1'b1};
            end else if (r_wait_cnt >= MAX_WAIT_V) begin
                w_wait_next = MAX_WAIT_V;
            end else begin
                w_wait_next = r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
            if (w_wait_next == MAX_WAIT_V) begin
                w_timeout_next = 1'b1;
            end
        end else begin
            w_state_next = RUN;
            w_wait_next  = '0;
            if (branch_taken_EX) begin
                // The ID instruction is squashed, so a load-use on it is moot.
                flush_IFID    = 1'b1;
                flush_IDEX    = 1'b1;
                w_branch_fire = 1'b1;
            end else if (w_lu) begin
                stall_IF   = 1'b1;
                stall_IFID = 1'b1;
                flush_IDEX = 1'b1;
            end
        end
    end

    // State, wait counter and sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            r_timeout  <= w_timeout_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_IF),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_branch_fire),
        .q     (flush_cnt)
    );

    assign timeout   = r_timeout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: stimulus table, directed multi-cycle sequences
// and randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int REG_AW   = 5;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic              rst;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              u1;
        logic              u2;
        logic [REG_AW-1:0] rd;
        logic              mr;
        logic              br;
        logic              req;
        logic              ack;
        logic [5:0]        exp; // {stall_IF, stall_IFID, flush_IFID, flush_IDEX, stall_IDEX, stall_EXMEM}
    } vec_t;

    logic              clk;
    logic              reset;
    logic [REG_AW-1:0] rs1_ID, rs2_ID, rd_EX;
    logic              use_rs1_ID, use_rs2_ID, memread_EX, branch_taken_EX;
    logic              mem_req_MEM, mem_ack_MEM;
    logic              stall_IF, stall_IFID, flush_IFID, flush_IDEX, stall_IDEX, stall_EXMEM;
    logic              timeout;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    hazard_state_t     dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_scnt, m_fcnt, m_frz_run;
    bit m_to, m_prev_frz;

    hazard_ctrl #(.REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .rd_EX(rd_EX), .memread_EX(memread_EX), .branch_taken_EX(branch_taken_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ack_MEM(mem_ack_MEM),
        .stall_IF(stall_IF), .stall_IFID(stall_IFID),
        .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
        .stall_IDEX(stall_IDEX), .stall_EXMEM(stall_EXMEM),
        .timeout(timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input int rs1, input int rs2,
                                input logic u1, input logic u2, input int rd,
                                input logic mr, input logic br, input logic req,
                                input logic ack, input logic [5:0] exp);
        vec_t v;
        v.rst = rst; v.rs1 = REG_AW'(rs1); v.rs2 = REG_AW'(rs2);
        v.u1 = u1; v.u2 = u2; v.rd = REG_AW'(rd);
        v.mr = mr; v.br = br; v.req = req; v.ack = ack; v.exp = exp;
        return v;
    endfunction

    // Output rules straight from the hazard definitions and their priority.
    function automatic logic [5:0] model_outs(input vec_t v);
        bit frz, lu;
        frz = v.req && !v.ack;
        lu  = v.mr && (v.rd != 0) &&
              ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        if (v.rst)      return 6'b000000;
        else if (frz)   return 6'b110011;
        else if (v.br)  return 6'b001100;
        else if (lu)    return 6'b110100;
        else            return 6'b000000;
    endfunction

    task automatic model_reset();
        m_scnt = 0; m_fcnt = 0; m_frz_run = 0; m_to = 0; m_prev_frz = 0;
    endtask

    // Advance the model across one rising edge with inputs v.
    task automatic model_edge(input vec_t v);
        logic [5:0] o;
        bit frz;
        o   = model_outs(v);
        frz = v.req && !v.ack;
        if (v.rst) begin
            model_reset();
        end else begin
            if (o[5] && m_scnt < CNT_MAX) m_scnt++;
            if (!frz && v.br && m_fcnt < CNT_MAX) m_fcnt++;
            m_frz_run  = frz ? m_frz_run + 1 : 0;
            if (m_frz_run >= MAX_WAIT) m_to = 1;
            m_prev_frz = frz;
        end
    endtask

    // Driver: apply one cycle of inputs, check mid-cycle, advance model at the edge.
    task automatic cycle(input vec_t v, input bit use_exp);
        logic [5:0] act;
        logic [5:0] m;
        reset = v.rst; rs1_ID = v.rs1; rs2_ID = v.rs2;
        use_rs1_ID = v.u1; use_rs2_ID = v.u2; rd_EX = v.rd;
        memread_EX = v.mr; branch_taken_EX = v.br;
        mem_req_MEM = v.req; mem_ack_MEM = v.ack;
        @(negedge clk);
        act = {stall_IF, stall_IFID, flush_IFID, flush_IDEX, stall_IDEX, stall_EXMEM};
        m   = model_outs(v);
        if (use_exp) chk("table_outs", 32'(act), 32'(v.exp));
        chk("model_outs", 32'(act), 32'(m));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("state", 32'(dbg_state), m_prev_frz ? 32'(MEMWAIT) : 32'(RUN));
        @(posedge clk);
        model_edge(v);
        #1;
    endtask

    vec_t tab[$];
    vec_t idle, rstv, frz, ack;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0);
        rstv = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0);
        frz  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b110011);
        ack  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000000);

        // Initial reset
        cycle_init();

        // Single-cycle vectors: rst rs1 rs2 u1 u2 rd mr br req ack exp
        tab.push_back(mk(1, 5, 0, 1, 0, 5, 1, 1, 1, 0, 6'b000000)); // reset masks all
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000)); // idle
        tab.push_back(mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 6'b110100)); // load-use rs1
        tab.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 6'b000000)); // rd = x0
        tab.push_back(mk(0, 3, 7, 1, 1, 7, 1, 0, 0, 0, 6'b110100)); // load-use rs2
        tab.push_back(mk(0, 9, 0, 0, 0, 9, 1, 0, 0, 0, 6'b000000)); // rs1 match, unused
        tab.push_back(mk(0, 9, 9, 1, 1, 9, 0, 0, 0, 0, 6'b000000)); // not a load
        tab.push_back(mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 6'b001100)); // branch beats lu
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001100)); // branch alone
        tab.push_back(mk(0, 4, 0, 1, 0, 4, 1, 0, 1, 1, 6'b110100)); // req+ack: no freeze
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000)); // stray ack
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b110011)); // freeze beats branch
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6'b001100)); // ack: branch acts
        foreach (tab[i]) cycle(tab[i], 1'b1);

        // Load-use once, then rd=x0: stall_cnt 1
        cycle(rstv, 0);
        cycle(mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 6'b110100), 1);
        cycle(mk(0, 5, 0, 1, 0, 5, 0, 0, 0, 0, 6'b000000), 1);
        cycle(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 6'b000000), 1);
        chk("seq_lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // Branch with load-use: flush_cnt 1, stall_cnt 0
        cycle(rstv, 0);
        cycle(mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 6'b001100), 1);
        chk("seq_br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("seq_br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Memory wait 3 cycles then ack
        cycle(rstv, 0);
        repeat (3) cycle(frz, 1);
        cycle(ack, 1);
        cycle(idle, 1);
        chk("seq_mw_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("seq_mw_timeout", 32'(timeout), 32'd0);
        chk("seq_mw_state", 32'(dbg_state), 32'(RUN));

        // Freeze overrides branch; branch acts in ack cycle
        cycle(rstv, 0);
        repeat (2) cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b110011), 1);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6'b001100), 1);
        chk("seq_fb_flush_cnt", 32'(flush_cnt), 32'd1);

        // Watchdog: 3 freeze edges no timeout, 4th sets it, sticky past ack
        cycle(rstv, 0);
        repeat (3) cycle(frz, 1);
        chk("seq_wd_before", 32'(timeout), 32'd0);
        cycle(frz, 1);
        chk("seq_wd_set", 32'(timeout), 32'd1);
        repeat (2) cycle(frz, 1);
        cycle(ack, 1);
        repeat (3) cycle(idle, 1);
        chk("seq_wd_sticky", 32'(timeout), 32'd1);
        cycle(rstv, 0);
        chk("seq_wd_cleared", 32'(timeout), 32'd0);

        // Reset while frozen in MEMWAIT
        repeat (2) cycle(frz, 1);
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000000), 1);
        chk("seq_rst_state", 32'(dbg_state), 32'(RUN));
        chk("seq_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        cycle(frz, 1);
        chk("seq_rst_refreeze", 32'(dbg_state), 32'(MEMWAIT));
        cycle(ack, 1);

        // Counter saturation
        cycle(rstv, 0);
        repeat (CNT_MAX + 4) cycle(mk(0, 2, 0, 1, 0, 2, 1, 0, 0, 0, 6'b110100), 1);
        chk("seq_sat_stall", 32'(stall_cnt), 32'(CNT_MAX));
        repeat (CNT_MAX + 4) cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001100), 1);
        chk("seq_sat_flush", 32'(flush_cnt), 32'(CNT_MAX));

        // Randomized traffic against the model
        cycle(rstv, 0);
        for (int n = 0; n < 3000; n++) begin
            vec_t v;
            v.rst = ($urandom_range(0, 99) == 0);
            v.rs1 = REG_AW'($urandom_range(0, 3));
            v.rs2 = REG_AW'($urandom_range(0, 3));
            v.rd  = REG_AW'($urandom_range(0, 3));
            v.u1  = 1'($urandom_range(0, 1));
            v.u2  = 1'($urandom_range(0, 1));
            v.mr  = 1'($urandom_range(0, 1));
            v.br  = ($urandom_range(0, 4) == 0);
            v.req = ($urandom_range(0, 2) != 0);
            v.ack = ($urandom_range(0, 3) == 0);
            v.exp = 6'b0;
            cycle(v, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic cycle_init();
        reset = 1'b1; rs1_ID = '0; rs2_ID = '0; rd_EX = '0;
        use_rs1_ID = 0; use_rs2_ID = 0; memread_EX = 0; branch_taken_EX = 0;
        mem_req_MEM = 0; mem_ack_MEM = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
    endtask

endmodule
